// File: rtl/keyed_step_pkg.sv
// Shared types and helpers for the keyed step sequencer.
// Holds the phase enum, default parameters, counter width and rotl.
package keyed_step_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } phase_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NUM_STEPS  = 8;
  localparam int DEF_KEY_W      = 4;
  localparam int DEF_ERR_THRESH = 5;
  localparam logic [3:0] DEF_KEY_VALUE = 4'b1011;

  localparam int STEP_W = $clog2(DEF_NUM_STEPS);

  // ERR_THRESH tops out at 255
  localparam int CNT_W = 8;

  // Rotate the low w bits of v left by s mod w; upper bits are zero.
  function automatic logic [63:0] rotl(
    input logic [63:0] v,
    input int          w,
    input int          s
  );
    logic [63:0] r;
    int          k;
    r = '0;
    k = s % w;
    for (int b = 0; b < 64; b++) begin
      if (b < w) r[6'((b + k) % w)] = v[6'(b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/keyed_step_seq_lock_err_counter.sv
// Saturating up/down error counter for the keyed step sequencer.
// Ports: clk, rst (async low), inc, dec -> count, at_thresh.
// LOCK_ERR_STICKY_EN: when defined, dec is ignored (count never falls).
module lock_err_counter
  import keyed_step_pkg::*;
#(
  parameter int ERR_THRESH = DEF_ERR_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_thresh
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(ERR_THRESH);

  logic up;
  logic down;

  assign up = inc && (count != THR);

`ifdef LOCK_ERR_STICKY_EN
  logic unused_dec;
  assign unused_dec = dec;
  assign down       = 1'b0;
`else
  assign down = dec && !inc && (count != '0);
`endif

  // falling edge matches the sequencer state register
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        up:      count <= count + 1'b1;
        down:    count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign at_thresh = (count == THR);

endmodule

// File: rtl/keyed_step_seq.sv
// Keyed step sequencer: wrong key bits divert into shadow steps.
// Ports: clk, rst, start, in_valid, x, keyinput -> busy, out_valid, y, done, corrupt.
// LOCK_ERR_STICKY_EN (in lock_err_counter) makes the error count sticky.
module keyed_step_seq
  import keyed_step_pkg::*;
#(
  parameter int              DATA_W     = DEF_DATA_W,
  parameter int              NUM_STEPS  = DEF_NUM_STEPS,
  parameter int              KEY_W      = DEF_KEY_W,
  parameter logic [KEY_W-1:0] KEY_VALUE = KEY_W'(DEF_KEY_VALUE),
  parameter int              ERR_THRESH = DEF_ERR_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  input  logic [KEY_W-1:0]  keyinput,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] y,
  output logic              done,
  output logic              corrupt
);

  localparam int IW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int GW = 1 << IW;

  localparam logic [IW-1:0]    LAST = IW'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0] THR  = CNT_W'(ERR_THRESH);

  phase_t          phase;
  phase_t          phase_n;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_n;
  logic            shadow;
  logic            shadow_n;
  logic            enter;
  logic            inc;
  logic            dec;
  logic            at_thresh;
  logic [CNT_W-1:0] err_cnt;
  logic [GW-1:0]   miss;

  // per-step key mismatch; steps past KEY_W are never keyed
  assign miss = GW'(keyinput ^ KEY_VALUE);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= IDLE;
      idx    <= '0;
      shadow <= 1'b0;
    end else begin
      phase  <= phase_n;
      idx    <= idx_n;
      shadow <= shadow_n;
    end
  end

  always_comb begin
    phase_n  = phase;
    idx_n    = idx;
    shadow_n = shadow;
    enter    = 1'b0;
    unique case (phase)
      IDLE: begin
        if (start) begin
          phase_n  = STEP;
          idx_n    = '0;
          shadow_n = miss[0];
          enter    = 1'b1;
        end
      end
      STEP: begin
        if (in_valid) begin
          if (idx == LAST) begin
            phase_n = DONE;
          end else begin
            idx_n    = idx + 1'b1;
            shadow_n = shadow | miss[idx_n];
            enter    = 1'b1;
          end
        end
      end
      DONE: begin
        phase_n  = IDLE;
        idx_n    = '0;
        shadow_n = 1'b0;
      end
      default: begin
        phase_n = IDLE;
      end
    endcase
  end

  // count every entry into a shadow step; a clean run retires one
  assign inc = enter && shadow_n && (err_cnt != THR);
  assign dec = (phase == DONE) && !shadow;

  lock_err_counter #(
    .ERR_THRESH(ERR_THRESH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .dec       (dec),
    .count     (err_cnt),
    .at_thresh (at_thresh)
  );

  assign corrupt = at_thresh;

  always_comb begin
    busy      = (phase != IDLE);
    out_valid = 1'b0;
    done      = 1'b0;
    y         = '0;
    unique case (phase)
      IDLE: begin
        busy = 1'b0;
      end
      STEP: begin
        out_valid = in_valid;
        // shadow beats still pulse but carry zero once saturated
        if (in_valid && !(at_thresh && shadow)) begin
          y = DATA_W'(rotl(64'(x), DATA_W, int'(idx)));
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_keyed_step_seq.sv
// Self-checking bench for keyed_step_seq.
// Reference model + y scoreboard; honours LOCK_ERR_STICKY_EN.
module tb_keyed_step_seq;

  localparam int         THR = 5;
  localparam logic [3:0] KV  = 4'b1011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] x = '0;
  logic [3:0] keyinput = '0;
  logic       busy;
  logic       out_valid;
  logic [7:0] y;
  logic       done;
  logic       corrupt;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] ex;

  int m_phase = 0;
  int m_idx = 0;
  int m_cnt = 0;
  bit m_sh = 1'b0;

  logic e_busy;
  logic e_ov;
  logic e_done;
  logic e_cor;

  always #5 clk = ~clk;

  keyed_step_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .x         (x),
    .keyinput  (keyinput),
    .busy      (busy),
    .out_valid (out_valid),
    .y         (y),
    .done      (done),
    .corrupt   (corrupt)
  );

  // scoreboard: every beat pulse must match the oldest expected y
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat_extra got y=%h, no beat expected", y);
      end else begin
        ex = q.pop_front();
        if (y !== ex) begin
          errors++;
          $display("FAIL beat_y got %h exp %h", y, ex);
        end
      end
    end else if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL beat_missing out_valid=%b exp y=%h", out_valid, q[0]);
      ex = q.pop_front();
    end
  end

  task automatic cycle(input logic st, input logic iv,
                       input logic [7:0] xv, input logic [3:0] kv);
    logic [15:0] t;
    logic [7:0]  r;
    @(posedge clk);
    start    = st;
    in_valid = iv;
    x        = xv;
    keyinput = kv;
    e_busy = (m_phase != 0);
    e_ov   = (m_phase == 1) && iv;
    e_done = (m_phase == 2);
    e_cor  = (m_cnt == THR);
    if (e_ov) begin
      t = {xv, xv} << (m_idx % 8);
      r = t[15:8];
      if (e_cor && m_sh) r = 8'h00;
      q.push_back(r);
    end
    case (m_phase)
      0: begin
        if (st) begin
          m_phase = 1;
          m_idx   = 0;
          m_sh    = (kv[0] != KV[0]);
          if (m_sh && m_cnt < THR) m_cnt++;
        end
      end
      1: begin
        if (iv) begin
          if (m_idx == 7) begin
            m_phase = 2;
          end else begin
            m_idx++;
            if (m_idx < 4) m_sh = m_sh | (kv[m_idx] != KV[m_idx]);
            if (m_sh && m_cnt < THR) m_cnt++;
          end
        end
      end
      default: begin
`ifndef LOCK_ERR_STICKY_EN
        if (!m_sh && m_cnt > 0) m_cnt--;
`endif
        m_sh    = 1'b0;
        m_phase = 0;
      end
    endcase
    #2;
  endtask

  task automatic run_seq(input logic [3:0] kv, input logic [7:0] xb);
    cycle(1'b1, 1'b0, 8'h00, kv);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, xb ^ 8'(i * 17), kv);
    cycle(1'b0, 1'b0, 8'h00, kv);
  endtask

  task automatic test_reset;
    @(posedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    #3;
    rst      = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    x        = 8'hff;
    keyinput = 4'hf;
    m_phase = 0;
    m_idx   = 0;
    m_cnt   = 0;
    m_sh    = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, done, corrupt, y} !== 12'h000) begin
      errors++;
      $display("FAIL reset_now got %b exp 0",
               {busy, out_valid, done, corrupt, y});
    end
    checks++;
    if (u_dut.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d exp 0", u_dut.err_cnt);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({busy, out_valid, done, corrupt, y} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold got %b exp 0",
               {busy, out_valid, done, corrupt, y});
    end
    @(posedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b1;
    #2;
    checks++;
    if ({busy, out_valid, done, corrupt, y} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release got %b exp 0",
               {busy, out_valid, done, corrupt, y});
    end
  endtask

  task automatic test_genuine;
    cycle(1'b1, 1'b0, 8'h00, KV);
    for (int i = 0; i < 8; i++) begin
      cycle((i == 3), 1'b1, 8'h01, KV);
      checks++;
      if ({busy, done, corrupt} !== {e_busy, e_done, e_cor}) begin
        errors++;
        $display("FAIL genuine_status beat %0d got %b exp %b", i,
                 {busy, done, corrupt}, {e_busy, e_done, e_cor});
      end
    end
    cycle(1'b1, 1'b0, 8'h00, KV);
    checks++;
    if (done !== 1'b1 || corrupt !== 1'b0) begin
      errors++;
      $display("FAIL genuine_done got done=%b corrupt=%b exp 1 0", done, corrupt);
    end
    cycle(1'b0, 1'b0, 8'h00, KV);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_bit0_wrong;
    for (int s = 0; s < 5; s++) begin
      cycle(1'b1, 1'b0, 8'h00, 4'b1010);
      for (int i = 0; i < 8; i++) begin
        cycle(1'b0, 1'b1, 8'h3c ^ 8'(s), 4'b1010);
        checks++;
        if ({busy, done, corrupt} !== {e_busy, e_done, e_cor}) begin
          errors++;
          $display("FAIL bit0_status seq %0d beat %0d got %b exp %b", s, i,
                   {busy, done, corrupt}, {e_busy, e_done, e_cor});
        end
      end
      cycle(1'b0, 1'b0, 8'h00, 4'b1010);
      if (s == 0) begin
        checks++;
        if (corrupt !== 1'b1) begin
          errors++;
          $display("FAIL bit0_corrupt got %b exp 1", corrupt);
        end
      end
    end
  endtask

  task automatic test_bit2_wrong;
    test_reset();
    cycle(1'b1, 1'b0, 8'h00, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h81, 4'b1111);
      checks++;
      if (corrupt !== e_cor) begin
        errors++;
        $display("FAIL bit2_corrupt beat %0d got %b exp %b", i, corrupt, e_cor);
      end
      if (i == 5) begin
        checks++;
        if (corrupt !== 1'b0 || y !== 8'h30) begin
          errors++;
          $display("FAIL bit2_beat5 got c=%b y=%h exp 0 30", corrupt, y);
        end
      end
      if (i == 6) begin
        checks++;
        if (corrupt !== 1'b1 || y !== 8'h00) begin
          errors++;
          $display("FAIL bit2_beat6 got c=%b y=%h exp 1 00", corrupt, y);
        end
      end
    end
    cycle(1'b0, 1'b0, 8'h00, 4'b1111);
  endtask

  task automatic test_stall;
    test_reset();
    cycle(1'b1, 1'b0, 8'h00, KV);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h11, KV);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 8'hee, KV);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall got ov=%b busy=%b exp 0 1", out_valid, busy);
      end
    end
    cycle(1'b0, 1'b1, 8'ha5, KV);
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h5a) begin
      errors++;
      $display("FAIL stall_resume got ov=%b y=%h exp 1 5a", out_valid, y);
    end
    for (int i = 5; i < 8; i++) cycle(1'b0, 1'b1, 8'h0f, KV);
    cycle(1'b0, 1'b0, 8'h00, KV);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got %b exp 1", done);
    end
  endtask

  task automatic test_mid_reset;
    cycle(1'b1, 1'b0, 8'h00, 4'b1010);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h42, 4'b1010);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b exp 1", busy);
    end
    test_reset();
    cycle(1'b1, 1'b0, 8'h00, KV);
    cycle(1'b0, 1'b1, 8'h03, KV);
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h03) begin
      errors++;
      $display("FAIL mid_restart got ov=%b y=%h exp 1 03", out_valid, y);
    end
    for (int i = 1; i < 8; i++) cycle(1'b0, 1'b1, 8'h03, KV);
    cycle(1'b0, 1'b0, 8'h00, KV);
  endtask

  task automatic test_sticky;
    logic exp_c;
`ifdef LOCK_ERR_STICKY_EN
    exp_c = 1'b1;
`else
    exp_c = 1'b0;
`endif
    test_reset();
    run_seq(4'b1010, 8'h5a);
    checks++;
    if (corrupt !== 1'b1) begin
      errors++;
      $display("FAIL sat_corrupt got %b exp 1", corrupt);
    end
    run_seq(KV, 8'hc3);
    cycle(1'b0, 1'b0, 8'h00, KV);
    checks++;
    if (corrupt !== exp_c) begin
      errors++;
      $display("FAIL sticky_corrupt got %b exp %b", corrupt, exp_c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_genuine();
    test_bit0_wrong();
    test_bit2_wrong();
    test_stall();
    test_mid_reset();
    test_sticky();
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
